// File: rtl/wave_sample_conditioner_if.sv
// Sample-stream interface between the microphone ADC front end and the waveform conditioner.
// Carries the raw sample input, control inputs, the decimated output stream and an FSM debug tap.
interface wave_sample_conditioner_if;
   // mic_in is taken on a rising clk_sample edge with mic_valid=1 (there is no back-pressure);
   // wave_valid is a one-cycle pulse marking the cycle in which wave_sample/peak_level changed.
   logic [11:0] mic_in;
   logic        mic_valid;
   logic        mode_peak;
   logic        freeze;
   logic [9:0]  wave_sample;
   logic        wave_valid;
   logic [9:0]  peak_level;
   logic [1:0]  dbg_state;

   modport master (
      output mic_in, mic_valid, mode_peak, freeze,
      input  wave_sample, wave_valid, peak_level, dbg_state
   );

   modport slave (
      input  mic_in, mic_valid, mode_peak, freeze,
      output wave_sample, wave_valid, peak_level, dbg_state
   );
endinterface

// File: rtl/wave_sample_conditioner.sv
// Decimates 12-bit ADC samples into the 10-bit display stream (average or peak window) plus a peak level.
// Optional macro WAVE_COND_DC_TRACK_EN replaces the fixed MID with a tracked DC offset.
module wave_sample_conditioner #(
   parameter int DECIM_LOG2 = 2,
   parameter int MID        = 2048
) (
   input  logic                        clk_sample,
   input  logic                        reset,
   wave_sample_conditioner_if.slave    bus
);

   localparam int WIN   = 1 << DECIM_LOG2;
   localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam int ACC_W = 12 + DECIM_LOG2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_EMIT   = 2'd2,
      S_FROZEN = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [11:0]      pmax_q, pmax_d;
   logic             mode_q, mode_d;
   logic [9:0]       wave_sample_q, wave_sample_d;
   logic             wave_valid_q, wave_valid_d;
   logic [9:0]       peak_level_q, peak_level_d;

   logic             take;
   logic             first_el;
   logic [11:0]      ref_code;
   logic signed [12:0] diff;
   logic [11:0]      mag;
   logic [11:0]      pmax_half;
   logic [9:0]       peak_sat;
   logic [9:0]       wave_avg;
   logic [9:0]       wave_pk;

`ifdef WAVE_COND_DC_TRACK_EN
   logic [15:0]        dc_q, dc_d;
   logic signed [16:0] dc_err;
   logic signed [16:0] dc_step;
   logic [11:0]        win_mean;
   logic signed [14:0] centred;
   logic signed [14:0] centred_q4;

   assign ref_code   = dc_q[15:4];
   assign dc_err     = $signed({1'b0, bus.mic_in, 4'b0000}) - $signed({1'b0, dc_q});
   assign dc_step    = dc_err >>> 8;
   // Subtracting the tracked offset recentres the trace on mid-screen regardless of mic bias.
   assign win_mean   = 12'(acc_q >> DECIM_LOG2);
   assign centred    = $signed({3'b000, win_mean}) - $signed({3'b000, ref_code}) + 15'sd2048;
   assign centred_q4 = centred >>> 2;
   assign wave_avg   = (centred_q4 < 15'sd0)    ? 10'd0 :
                       (centred_q4 > 15'sd1023) ? 10'd1023 : centred_q4[9:0];
`else
   assign ref_code   = 12'(MID);
   assign wave_avg   = 10'(acc_q >> (DECIM_LOG2 + 2));
`endif

   assign diff      = $signed({1'b0, bus.mic_in}) - $signed({1'b0, ref_code});
   assign mag       = diff[12] ? 12'(-diff) : diff[11:0];
   assign pmax_half = pmax_q >> 1;
   assign peak_sat  = (pmax_half > 12'd1023) ? 10'd1023 : pmax_half[9:0];
   assign wave_pk   = 10'(acc_q >> 2);
   // cnt is zero both in IDLE and in EMIT, so an accepted sample there opens a new window.
   assign first_el  = (cnt_q == '0);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      pmax_d        = pmax_q;
      mode_d        = mode_q;
      wave_sample_d = wave_sample_q;
      wave_valid_d  = 1'b0;
      peak_level_d  = peak_level_q;
      take          = 1'b0;
`ifdef WAVE_COND_DC_TRACK_EN
      dc_d          = dc_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.mic_valid && !bus.freeze) take = 1'b1;
         end
         S_ACCUM: begin
            if (bus.freeze) begin
               state_d = S_FROZEN;
               cnt_d   = '0;
               acc_d   = '0;
               pmax_d  = '0;
            end else if (bus.mic_valid) begin
               take = 1'b1;
            end
         end
         S_EMIT: begin
            wave_valid_d  = 1'b1;
            wave_sample_d = mode_q ? wave_pk : wave_avg;
            peak_level_d  = peak_sat;
            cnt_d         = '0;
            acc_d         = '0;
            pmax_d        = '0;
            if (bus.freeze) begin
               state_d = S_FROZEN;
            end else begin
               state_d = S_ACCUM;
               if (bus.mic_valid) take = 1'b1;
            end
         end
         S_FROZEN: begin
            if (!bus.freeze) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (take) begin
         if (first_el) begin
            mode_d = bus.mode_peak;
            acc_d  = ACC_W'(bus.mic_in);
            pmax_d = mag;
         end else begin
            if (mode_q) begin
               acc_d = (ACC_W'(bus.mic_in) > acc_q) ? ACC_W'(bus.mic_in) : acc_q;
            end else begin
               acc_d = acc_q + ACC_W'(bus.mic_in);
            end
            pmax_d = (mag > pmax_q) ? mag : pmax_q;
         end
         if (cnt_q == CNT_LAST) begin
            state_d = S_EMIT;
            cnt_d   = '0;
         end else begin
            state_d = S_ACCUM;
            cnt_d   = cnt_q + 1'b1;
         end
`ifdef WAVE_COND_DC_TRACK_EN
         dc_d = 16'($signed({1'b0, dc_q}) + dc_step);
`endif
      end
   end

   always_ff @(posedge clk_sample) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         acc_q         <= '0;
         pmax_q        <= '0;
         mode_q        <= 1'b0;
         wave_sample_q <= 10'd512;
         wave_valid_q  <= 1'b0;
         peak_level_q  <= 10'd0;
`ifdef WAVE_COND_DC_TRACK_EN
         dc_q          <= 16'(MID << 4);
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         acc_q         <= acc_d;
         pmax_q        <= pmax_d;
         mode_q        <= mode_d;
         wave_sample_q <= wave_sample_d;
         wave_valid_q  <= wave_valid_d;
         peak_level_q  <= peak_level_d;
`ifdef WAVE_COND_DC_TRACK_EN
         dc_q          <= dc_d;
`endif
      end
   end

   assign bus.wave_sample = wave_sample_q;
   assign bus.wave_valid  = wave_valid_q;
   assign bus.peak_level  = peak_level_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_wave_sample_conditioner.sv
// Self-checking bench for wave_sample_conditioner (default build, DECIM_LOG2=2, MID=2048).
// A window model pushes expected {wave_sample, peak_level} pairs; a monitor pops them on each wave_valid.
module tb_wave_sample_conditioner;

   logic clk;
   logic reset;

   wave_sample_conditioner_if bus ();

   wave_sample_conditioner #(.DECIM_LOG2(2), .MID(2048)) dut (
      .clk_sample (clk),
      .reset      (reset),
      .bus        (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int emits_seen = 0;
   int emits_exp  = 0;

   logic [19:0] exp_q[$];
   int          win_q[$];
   bit          win_mode;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference window model: 4 samples, mode taken from the first sample of the window
   task automatic model_accept(input int d, input bit m);
      int sum, mx, mmax, mg, pl, ws;
      if (win_q.size() == 0) win_mode = m;
      win_q.push_back(d);
      if (win_q.size() == 4) begin
         sum = 0; mx = 0; mmax = 0;
         foreach (win_q[i]) begin
            sum += win_q[i];
            if (win_q[i] > mx) mx = win_q[i];
            mg = (win_q[i] >= 2048) ? win_q[i] - 2048 : 2048 - win_q[i];
            if (mg > mmax) mmax = mg;
         end
         ws = win_mode ? (mx / 4) : (sum / 16);
         pl = mmax / 2;
         if (pl > 1023) pl = 1023;
         exp_q.push_back({ws[9:0], pl[9:0]});
         emits_exp++;
         win_q.delete();
      end
   endtask

   // driver: called at a negedge, holds inputs for one full cycle
   task automatic drive(input bit v, input int d, input bit m, input bit f);
      bus.mic_valid = v;
      bus.mic_in    = d[11:0];
      bus.mode_peak = m;
      bus.freeze    = f;
      if (f) win_q.delete();
      else if (v) model_accept(d, m);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.mic_valid = 1'b0;
      bus.freeze    = 1'b0;
      win_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_wave_sample"}, bus.wave_sample, 10'd512);
      check({tag, "_wave_valid"},  bus.wave_valid, 1'b0);
      check({tag, "_peak_level"},  bus.peak_level, 10'd0);
      check({tag, "_state"},       bus.dbg_state, 2'd0);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [19:0] e;
      if (!reset && bus.wave_valid) begin
         emits_seen++;
         if (exp_q.size() == 0) begin
            check("unexpected_emit", {22'd0, bus.wave_sample}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("wave_sample", bus.wave_sample, e[19:10]);
            check("peak_level",  bus.peak_level,  e[9:0]);
         end
      end
   end

   initial begin
      int vals[4];
      int tv[7];
      int tval[7];
      int held;

      reset = 1'b1;
      bus.mic_in = '0; bus.mic_valid = 1'b0; bus.mode_peak = 1'b0; bus.freeze = 1'b0;
      @(negedge clk);
      do_reset();
      check_reset_state("reset");

      // average window
      vals = '{1000, 2000, 3000, 4000};
      foreach (vals[i]) drive(1, vals[i], 0, 0);
      repeat (3) drive(0, 0, 0, 0);

      // peak window with saturated peak level
      vals = '{100, 4095, 50, 0};
      foreach (vals[i]) drive(1, vals[i], 1, 0);
      repeat (3) drive(0, 0, 0, 0);
      check("peak_hold", bus.wave_sample, 10'd1023);

      // freeze after two samples discards the partial window
      drive(1, 3000, 0, 0);
      drive(1, 3100, 0, 0);
      repeat (3) drive(0, 0, 0, 1);
      check("frozen_state", bus.dbg_state, 2'd3);
      check("frozen_hold", bus.wave_sample, 10'd1023);
      drive(0, 0, 0, 0);
      repeat (4) drive(1, 2048, 0, 0);
      repeat (3) drive(0, 0, 0, 0);

      // sparse mic_valid; 4th accepted sample emits one cycle later
      tv   = '{1, 0, 0, 1, 0, 1, 1};
      tval = '{500, 9, 9, 1500, 9, 2500, 3500};
      foreach (tv[i]) drive(tv[i], tval[i], 0, 0);
      check("lat_not_early", bus.wave_valid, 1'b0);
      check("lat_emit_state", bus.dbg_state, 2'd2);
      drive(1, 4000, 1, 0);
      check("lat_emit", bus.wave_valid, 1'b1);
      drive(1, 10, 0, 0);
      drive(1, 3000, 0, 0);
      drive(1, 200, 0, 0);
      repeat (3) drive(0, 0, 0, 0);

      // reset mid-window
      held = emits_seen;
      repeat (3) drive(1, 3900, 0, 0);
      do_reset();
      check_reset_state("midreset");
      vals = '{2100, 2200, 2300, 2400};
      foreach (vals[i]) drive(1, vals[i], 0, 0);
      repeat (3) drive(0, 0, 0, 0);
      check("fresh_window", emits_seen, held + 1);

      // random stream
      repeat (300) drive($urandom_range(0, 3) != 0, $urandom_range(0, 4095), $urandom_range(0, 1), 0);
      repeat (4) drive(0, 0, 0, 0);

      check("queue_drained", exp_q.size(), 0);
      check("emit_count", emits_seen, emits_exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
